// File: rtl/axi_rd_engine_pkg.sv
//------------------------------------------------------------------------------
// axi_rd_engine_pkg : AXI constants and engine state encoding
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package axi_rd_engine_pkg;

  localparam logic [1:0]  AXI_BURST_INCR   = 2'b01;
  localparam logic [2:0]  AXI_SIZE_64B     = 3'd6;
  localparam int unsigned AXI_4KB_BOUNDARY = 4096;
  localparam int unsigned AXI_BEAT_BYTES   = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/axi_bus_t.sv
//------------------------------------------------------------------------------
// axi_bus_t : AXI4 bus bundle with master and slave views
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface axi_bus_t #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

`default_nettype wire

// File: rtl/axi_rd_engine.sv
//------------------------------------------------------------------------------
// axi_rd_engine : splits a beat-count read command into 4KB-safe AXI bursts
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axi_rd_engine
  import axi_rd_engine_pkg::*;
#(
  parameter int M_AXI_ADDR_WIDTH = 64,
  parameter int M_AXI_DATA_WIDTH = 512,
  parameter int M_AXI_ID_WIDTH   = 4,
  parameter int MAX_BURST_BEATS  = 64,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]                 cmd_beats,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [M_AXI_DATA_WIDTH-1:0] out_data,
  output logic                        out_last,
  output logic                        done,
  axi_bus_t.master                    m_axi
);

  localparam int          OUT_W         = $clog2(MAX_OUTSTANDING + 1);
  localparam int          BEAT_BITS     = $clog2(AXI_BEAT_BYTES);
  localparam int          PAGE_BITS     = $clog2(AXI_4KB_BOUNDARY);
  localparam logic [31:0] BEATS_PER_4KB = 32'(AXI_4KB_BOUNDARY / AXI_BEAT_BYTES);

  rd_state_e                   r_state;
  rd_state_e                   w_state_nxt;
  logic [M_AXI_ADDR_WIDTH-1:0] r_addr;
  logic [31:0]                 r_remaining;
  logic [31:0]                 r_beat_cnt;
  logic [31:0]                 r_last_idx;
  logic [OUT_W-1:0]            r_outstanding;

  logic        w_cmd_ready;
  logic        w_arvalid;
  logic        w_done;
  logic        w_cmd_hs;
  logic        w_ar_hs;
  logic        w_r_hs;
  logic        w_rlast_hs;
  logic        w_last_beat;
  logic        w_final_hs;
  logic [31:0] w_burst_len;
  logic        w_unused;

  // Burst may not exceed the remaining beats, the burst cap, or the 4KB page.
  function automatic logic [31:0] f_burst_len(
    input logic [31:0]                 remaining,
    input logic [M_AXI_ADDR_WIDTH-1:0] addr
  );
    logic [31:0] len;
    logic [31:0] to_boundary;
    to_boundary = BEATS_PER_4KB - 32'(addr[PAGE_BITS-1:BEAT_BITS]);
    len = remaining;
    if (len > 32'(MAX_BURST_BEATS)) len = 32'(MAX_BURST_BEATS);
    if (len > to_boundary)          len = to_boundary;
    return len;
  endfunction

  assign w_burst_len = f_burst_len(r_remaining, r_addr);
  assign w_cmd_hs    = cmd_valid && w_cmd_ready;
  assign w_ar_hs     = w_arvalid && m_axi.arready;
  assign w_r_hs      = m_axi.rvalid && out_ready;
  assign w_rlast_hs  = w_r_hs && m_axi.rlast;
  assign w_last_beat = (r_state != IDLE) && (r_beat_cnt == r_last_idx);
  assign w_final_hs  = (r_state == DRAIN) && w_r_hs && w_last_beat;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cmd_hs) w_state_nxt = ISSUE;
      ISSUE:   if (w_ar_hs && (w_burst_len == r_remaining)) w_state_nxt = DRAIN;
      DRAIN:   if (w_final_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Gated by rst so the reset cycle itself presents a quiet interface.
  always_comb begin
    w_cmd_ready = 1'b0;
    w_arvalid   = 1'b0;
    w_done      = 1'b0;
    if (!rst) begin
      w_cmd_ready = (r_state == IDLE);
      w_arvalid   = (r_state == ISSUE) && (r_outstanding < OUT_W'(MAX_OUTSTANDING));
      w_done      = w_final_hs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr        <= '0;
      r_remaining   <= '0;
      r_beat_cnt    <= '0;
      r_last_idx    <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_addr      <= cmd_addr;
        r_remaining <= cmd_beats;
        r_last_idx  <= cmd_beats - 32'd1;
        r_beat_cnt  <= '0;
      end else begin
        if (w_ar_hs) begin
          r_addr      <= r_addr + (M_AXI_ADDR_WIDTH'(w_burst_len) << BEAT_BITS);
          r_remaining <= r_remaining - w_burst_len;
        end
        if (w_r_hs && (r_state != IDLE)) r_beat_cnt <= r_beat_cnt + 32'd1;
      end
      case ({w_ar_hs, w_rlast_hs})
        2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign done      = w_done;
  assign out_valid = m_axi.rvalid;
  assign out_data  = m_axi.rdata;
  assign out_last  = w_last_beat;

  assign m_axi.arid    = '0;
  assign m_axi.araddr  = r_addr;
  assign m_axi.arlen   = 8'(w_burst_len - 32'd1);
  assign m_axi.arsize  = AXI_SIZE_64B;
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.arvalid = w_arvalid;
  assign m_axi.rready  = out_ready;

  // Read-only engine: write channels are parked.
  assign m_axi.awid    = '0;
  assign m_axi.awaddr  = '0;
  assign m_axi.awlen   = '0;
  assign m_axi.awsize  = '0;
  assign m_axi.awburst = '0;
  assign m_axi.awvalid = 1'b0;
  assign m_axi.wdata   = '0;
  assign m_axi.wstrb   = '0;
  assign m_axi.wlast   = 1'b0;
  assign m_axi.wvalid  = 1'b0;
  assign m_axi.bready  = 1'b1;

  assign w_unused = ^{m_axi.awready, m_axi.wready, m_axi.bid, m_axi.bresp,
                      m_axi.bvalid, m_axi.rid, m_axi.rresp};

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_engine.sv
//------------------------------------------------------------------------------
// tb_axi_rd_engine : directed self-checking bench for axi_rd_engine
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_axi_rd_engine;
  import axi_rd_engine_pkg::*;

  localparam int AW = 64;
  localparam int DW = 512;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_beats;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          done;

  axi_bus_t #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) m_axi ();

  axi_rd_engine #(
    .M_AXI_ADDR_WIDTH(AW), .M_AXI_DATA_WIDTH(DW), .M_AXI_ID_WIDTH(IW),
    .MAX_BURST_BEATS(64), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .m_axi(m_axi)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] ar_addr_q[$];
  int          ar_len_q[$];
  int          pend_q[$];
  int          r_beat, r_seq, exp_beats;
  bit          r_en, bp_en, ar_rand, cmd_hs_seen, timed_out;
  int          out_cnt, data_err, last_err, n_done, mirror_err, inflight, max_inflight;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    ar_addr_q.delete(); ar_len_q.delete();
    out_cnt = 0; data_err = 0; last_err = 0; n_done = 0; mirror_err = 0;
    max_inflight = 0; r_seq = 0; cmd_hs_seen = 0; timed_out = 0;
  endtask

  // Sample at negedge, then update slave/sink drives just after the posedge.
  task automatic tick();
    bit r_hs;
    @(negedge clk);
    if (cmd_valid && cmd_ready) cmd_hs_seen = 1;
    if (m_axi.arvalid && m_axi.arready) begin
      ar_addr_q.push_back(m_axi.araddr);
      ar_len_q.push_back(int'(m_axi.arlen));
      pend_q.push_back(int'(m_axi.arlen) + 1);
      inflight++;
      if (inflight > max_inflight) max_inflight = inflight;
    end
    if (m_axi.rready !== out_ready || out_valid !== m_axi.rvalid || out_data !== m_axi.rdata)
      mirror_err++;
    r_hs = m_axi.rvalid && m_axi.rready;
    if (r_hs) begin
      if (out_data[31:0] !== 32'(out_cnt)) data_err++;
      if (out_last !== (out_cnt == exp_beats - 1)) last_err++;
      if (done !== (out_cnt == exp_beats - 1)) last_err++;
      out_cnt++;
      if (m_axi.rlast) inflight--;
    end else if (done !== 1'b0) last_err++;
    if (done === 1'b1) n_done++;
    @(posedge clk); #1;
    if (r_hs) begin
      r_beat++; r_seq++;
      if (pend_q.size() > 0 && r_beat == pend_q[0]) begin
        void'(pend_q.pop_front());
        r_beat = 0;
      end
    end
    m_axi.rvalid = r_en && (pend_q.size() > 0);
    m_axi.rdata  = DW'(r_seq);
    m_axi.rlast  = 1'b0;
    if (pend_q.size() > 0) m_axi.rlast = (r_beat == pend_q[0] - 1);
    out_ready     = bp_en   ? 1'($urandom_range(0, 1)) : 1'b1;
    m_axi.arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic start_cmd(input logic [63:0] addr, input int beats);
    clear_model();
    exp_beats = beats;
    cmd_valid = 1'b1; cmd_addr = addr; cmd_beats = 32'(beats);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (n_done == 0 && n < budget) begin tick(); n++; end
    timed_out = (n_done == 0);
  endtask

  task automatic check_run(input string tag, input int beats, input int n_ar);
    check({tag, "_accept"},  64'(cmd_hs_seen), 64'd1);
    check({tag, "_timeout"}, 64'(timed_out), 64'd0);
    check({tag, "_beats"},   64'(out_cnt), 64'(beats));
    check({tag, "_order"},   64'(data_err), 64'd0);
    check({tag, "_last"},    64'(last_err), 64'd0);
    check({tag, "_done"},    64'(n_done), 64'd1);
    check({tag, "_mirror"},  64'(mirror_err), 64'd0);
    check({tag, "_nar"},     64'(ar_addr_q.size()), 64'(n_ar));
  endtask

  task automatic check_ar(input string tag, input int idx, input logic [63:0] addr, input int len);
    logic [63:0] a;
    int l;
    a = (idx < ar_addr_q.size()) ? ar_addr_q[idx] : '1;
    l = (idx < ar_len_q.size())  ? ar_len_q[idx]  : -1;
    check({tag, "_araddr"}, a, addr);
    check({tag, "_arlen"},  64'(l), 64'(len));
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0; out_ready = 1'b1;
    m_axi.arready = 1'b1; m_axi.rvalid = 1'b0; m_axi.rdata = '0; m_axi.rlast = 1'b0;
    m_axi.rid = '0; m_axi.rresp = '0; m_axi.awready = 1'b0; m_axi.wready = 1'b0;
    m_axi.bvalid = 1'b0; m_axi.bid = '0; m_axi.bresp = '0;
    r_en = 1; bp_en = 0; ar_rand = 0; r_beat = 0; inflight = 0;
    clear_model();

    @(negedge clk);
    check("rst_cmd_ready_lo", 64'(cmd_ready), 64'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready_hi", 64'(cmd_ready), 64'd1);
    check("rst_arvalid",      64'(m_axi.arvalid), 64'd0);
    check("rst_done",         64'(done), 64'd0);
    check("rst_bready",       64'(m_axi.bready), 64'd1);
    check("rst_awvalid",      64'(m_axi.awvalid), 64'd0);
    @(posedge clk); #1;

    // single burst
    start_cmd(64'h0, 16); wait_done(200);
    check_run("single", 16, 1);
    check_ar("single0", 0, 64'h0, 15);
    tick();
    check("single_idle", 64'(cmd_ready), 64'd1);

    // multi-burst with random arready
    ar_rand = 1;
    start_cmd(64'h0, 200); wait_done(2000);
    ar_rand = 0;
    check_run("multi", 200, 4);
    check_ar("multi0", 0, 64'h0000, 63);
    check_ar("multi1", 1, 64'h1000, 63);
    check_ar("multi2", 2, 64'h2000, 63);
    check_ar("multi3", 3, 64'h3000, 7);

    // 4KB split
    start_cmd(64'hFC0, 4); wait_done(200);
    check_run("split", 4, 2);
    check_ar("split0", 0, 64'hFC0, 0);
    check_ar("split1", 1, 64'h1000, 2);

    // outstanding limit with R withheld
    r_en = 0;
    start_cmd(64'h0, 512);
    for (int i = 0; i < 20; i++) tick();
    check("lim_nar_held",  64'(ar_addr_q.size()), 64'd4);
    check("lim_arvalid",   64'(m_axi.arvalid), 64'd0);
    r_en = 1;
    wait_done(3000);
    check_run("lim", 512, 8);
    check("lim_max_inflight", 64'(max_inflight), 64'd4);

    // backpressure
    bp_en = 1;
    start_cmd(64'h40, 100); wait_done(2000);
    bp_en = 0;
    check_run("bp", 100, 2);
    check_ar("bp0", 0, 64'h40, 62);
    check_ar("bp1", 1, 64'h1000, 36);

    // reset mid-ISSUE
    r_en = 0;
    start_cmd(64'h0, 512);
    tick(); tick();
    rst = 1'b1;
    @(negedge clk);
    check("rmid_cmd_ready_lo", 64'(cmd_ready), 64'd0);
    check("rmid_arvalid_lo",   64'(m_axi.arvalid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pend_q.delete(); r_beat = 0; inflight = 0; m_axi.rvalid = 1'b0; m_axi.rlast = 1'b0;
    @(negedge clk);
    check("rmid_cmd_ready_hi", 64'(cmd_ready), 64'd1);
    check("rmid_arvalid",      64'(m_axi.arvalid), 64'd0);
    check("rmid_done",         64'(done), 64'd0);
    @(posedge clk); #1;
    r_en = 1;
    start_cmd(64'h2000, 8); wait_done(200);
    check_run("post", 8, 1);
    check_ar("post0", 0, 64'h2000, 7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
